param_pwm_compare: RTL and testbench

- Downstream consumer of the parameterized modulo counter.
- Samples the counter value bus each clock and compares it against a duty threshold.
- Produces a registered PWM output, a compare-match strobe and a period strobe.
- The threshold is loaded through a valid/ready handshake into a shadow register. It takes effect only at counter wrap, so periods are never glitched. Supports free-running and one-shot modes.

---
 rtl/param_pwm_pkg.sv | 26 ++
 rtl/param_wrap_detect.sv | 33 +++
 rtl/param_pwm_compare.sv | 151 +++++++++++++++
 tb/tb_param_pwm_compare.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/param_pwm_pkg.sv
// Shared types and helpers for the PWM compare channel.
//   pwm_state_e : channel FSM state
//   cnt_width() : counter/duty width for a given modulus
//   pwm_cfg_t   : duty/mode payload carried through the shadow registers
package param_pwm_pkg;

  // Widest duty the payload can carry; a 32-bit modulus never needs more.
  localparam int unsigned DUTY_W_MAX = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } pwm_state_e;

  typedef struct packed {
    logic [DUTY_W_MAX-1:0] duty;
    logic                  oneshot;
  } pwm_cfg_t;

  // Counter width for modulus mod; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned mod);
    return (mod > 1) ? int'($clog2(mod)) : 1;
  endfunction

endpackage

// File: rtl/param_wrap_detect.sv
// Wrap detector for an upstream modulo counter.
// Ports:
//   clk, rst_ : clock, async active-low reset
//   cnt_in    : sampled counter value
//   wrap_c    : combinational, high when cnt_in dropped below last cycle's value
module param_wrap_detect #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [W-1:0] cnt_in,
  output logic         wrap_c
);

  logic [W-1:0] cnt_prev_q;
  logic [W-1:0] cnt_prev_d;

  always_comb begin : prev_next
    cnt_prev_d = cnt_in;
  end

  always_ff @(posedge clk or negedge rst_) begin : prev_reg
    if (!rst_) begin
      cnt_prev_q <= '0;
    end else begin
      cnt_prev_q <= cnt_prev_d;
    end
  end

  // A stalled (equal) counter is not a wrap.
  assign wrap_c = (cnt_in < cnt_prev_q);

endmodule

// File: rtl/param_pwm_compare.sv
// PWM compare channel fed by an external modulo counter.
// Ports:
//   clk, rst_     : clock, async active-low reset
//   cnt_in        : upstream counter value (0..MOD-1)
//   en            : run enable (level)
//   cfg_valid/cfg_ready, cfg_duty, cfg_oneshot : shadow-config handshake
//   pwm_out       : registered PWM (cnt_in < active duty while running)
//   match_pulse   : strobe when cnt_in hits a nonzero active duty in RUN
//   period_pulse  : strobe on counter wrap in RUN
//   busy          : channel is (about to be) in RUN
module param_pwm_compare
  import param_pwm_pkg::*;
#(
  parameter  int unsigned MOD = 40000,
  localparam int unsigned W   = cnt_width(MOD)
) (
  input  logic         clk,
  input  logic         rst_,
  input  logic [W-1:0] cnt_in,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_duty,
  input  logic         cfg_oneshot,
  output logic         pwm_out,
  output logic         match_pulse,
  output logic         period_pulse,
  output logic         busy
);

  logic wrap_c;

  pwm_state_e state_q, state_d;
  pwm_cfg_t   pend_q, pend_d;
  pwm_cfg_t   act_q, act_d;
  logic       pend_valid_q, pend_valid_d;
  logic       act_valid_q, act_valid_d;
  logic       pwm_q, pwm_d;
  logic       match_q, match_d;
  logic       period_q, period_d;
  logic       busy_q, busy_d;
  logic       ready_q, ready_d;

  logic                  xfer_c;
  logic                  load_c;
  logic                  run_now_c;
  logic                  run_next_c;
  logic [DUTY_W_MAX-1:0] cnt_ext_c;
  logic [DUTY_W_MAX-1:0] duty_eff_c;

  param_wrap_detect #(
    .W (W)
  ) u_wrap (
    .clk    (clk),
    .rst_   (rst_),
    .cnt_in (cnt_in),
    .wrap_c (wrap_c)
  );

  // Shadow slot: accept into pending when free, promote to active on wrap.
  // A transfer needs an empty slot and a load needs a full one, so both
  // can never happen in the same cycle.
  always_comb begin : shadow_next
    xfer_c       = cfg_valid && !pend_valid_q;
    load_c       = wrap_c && pend_valid_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;
    act_d        = act_q;
    act_valid_d  = act_valid_q;
    if (load_c) begin
      act_d        = pend_q;
      act_valid_d  = 1'b1;
      pend_valid_d = 1'b0;
    end
    if (xfer_c) begin
      pend_d.duty    = DUTY_W_MAX'(cfg_duty);
      pend_d.oneshot = cfg_oneshot;
      pend_valid_d   = 1'b1;
    end
  end

  // FSM next state and registered-output next values.
  always_comb begin : fsm_next
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (wrap_c && en && (act_valid_q || pend_valid_q)) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Oneshot decision uses the mode active before any wrap-time load.
        if (!en) begin
          state_d = ST_IDLE;
        end else if (wrap_c && act_q.oneshot) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (!en) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    run_now_c  = (state_q == ST_RUN);
    run_next_c = (state_d == ST_RUN);
    cnt_ext_c  = DUTY_W_MAX'(cnt_in);
    duty_eff_c = act_d.duty;  // post-load duty when a load happens this cycle

    pwm_d    = run_next_c && (cnt_ext_c < duty_eff_c);
    match_d  = run_now_c && (cnt_ext_c == duty_eff_c) && (duty_eff_c != '0);
    period_d = run_now_c && wrap_c;
    busy_d   = run_next_c;
    ready_d  = !pend_valid_d;
  end

  always_ff @(posedge clk or negedge rst_) begin : regs
    if (!rst_) begin
      state_q      <= ST_IDLE;
      pend_q       <= '0;
      act_q        <= '0;
      pend_valid_q <= 1'b0;
      act_valid_q  <= 1'b0;
      pwm_q        <= 1'b0;
      match_q      <= 1'b0;
      period_q     <= 1'b0;
      busy_q       <= 1'b0;
      ready_q      <= 1'b1;
    end else begin
      state_q      <= state_d;
      pend_q       <= pend_d;
      act_q        <= act_d;
      pend_valid_q <= pend_valid_d;
      act_valid_q  <= act_valid_d;
      pwm_q        <= pwm_d;
      match_q      <= match_d;
      period_q     <= period_d;
      busy_q       <= busy_d;
      ready_q      <= ready_d;
    end
  end

  assign pwm_out      = pwm_q;
  assign match_pulse  = match_q;
  assign period_pulse = period_q;
  assign busy         = busy_q;
  assign cfg_ready    = ready_q;

endmodule

// File: tb/tb_param_pwm_compare.sv
// Directed bench for param_pwm_compare with MOD=10 (W=4).
// Expected outputs are 10-bit masks indexed by the cnt_in value driven in
// that cycle; the registered outputs are checked 1 time unit after the edge.
module tb_param_pwm_compare;

  localparam int unsigned MOD = 10;
  localparam int unsigned W   = 4;

  logic         clk = 1'b0;
  logic         rst_;
  logic [W-1:0] cnt_in;
  logic         en;
  logic         cfg_valid;
  logic         cfg_ready;
  logic [W-1:0] cfg_duty;
  logic         cfg_oneshot;
  logic         pwm_out;
  logic         match_pulse;
  logic         period_pulse;
  logic         busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_pwm_compare #(.MOD(MOD)) dut (
    .clk          (clk),
    .rst_         (rst_),
    .cnt_in       (cnt_in),
    .en           (en),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_duty     (cfg_duty),
    .cfg_oneshot  (cfg_oneshot),
    .pwm_out      (pwm_out),
    .match_pulse  (match_pulse),
    .period_pulse (period_pulse),
    .busy         (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  // Drive cnt_in = start..start+n-1; optionally offer a config at cnt offer_at
  // and hold it until accepted. Masks give the expected output per cnt value.
  task automatic run(input string tag, input int start, input int n,
                     input logic [9:0] en_m, input int offer_at,
                     input logic [W-1:0] duty, input logic oneshot,
                     input logic [9:0] pwm_m, input logic [9:0] match_m,
                     input logic [9:0] per_m, input logic [9:0] busy_m,
                     input logic [9:0] rdy_m);
    for (int k = 0; k < n; k++) begin
      int   c;
      logic acc;
      c  = start + k;
      en = en_m[c];
      if (c == offer_at) begin
        cfg_valid   = 1'b1;
        cfg_duty    = duty;
        cfg_oneshot = oneshot;
      end
      acc    = cfg_valid && cfg_ready;
      cnt_in = W'(c);
      tick();
      if (acc) cfg_valid = 1'b0;
      chk($sformatf("%s.pwm@%0d", tag, c), pwm_out, pwm_m[c]);
      chk($sformatf("%s.match@%0d", tag, c), match_pulse, match_m[c]);
      chk($sformatf("%s.period@%0d", tag, c), period_pulse, per_m[c]);
      chk($sformatf("%s.busy@%0d", tag, c), busy, busy_m[c]);
      chk($sformatf("%s.ready@%0d", tag, c), cfg_ready, rdy_m[c]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst_        = 1'b0;
    en          = 1'b0;
    cfg_valid   = 1'b0;
    cfg_duty    = '0;
    cfg_oneshot = 1'b0;
    cnt_in      = '0;
    tick();
    tick();
    chk("rst.pwm", pwm_out, 1'b0);
    chk("rst.match", match_pulse, 1'b0);
    chk("rst.period", period_pulse, 1'b0);
    chk("rst.busy", busy, 1'b0);
    chk("rst.ready", cfg_ready, 1'b1);
    rst_ = 1'b1;

    // Load duty=4 free-running; first wrap starts the channel.
    run("load4", 0, 10, 10'h3FF, 0, 4'd4, 1'b0,
        10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000);
    run("run4", 0, 10, 10'h3FF, -1, 4'd0, 1'b0,
        10'b0000001111, 10'b0000010000, 10'b0000000000, 10'b1111111111, 10'b1111111111);
    // duty=7 accepted mid-period; this period keeps duty 4.
    run("shadow7", 0, 10, 10'h3FF, 5, 4'd7, 1'b0,
        10'b0000001111, 10'b0000010000, 10'b0000000001, 10'b1111111111, 10'b0000011111);
    // duty=2 offered on the wrap: refused that cycle, accepted the next.
    run("run7", 0, 10, 10'h3FF, 0, 4'd2, 1'b0,
        10'b0001111111, 10'b0010000000, 10'b0000000001, 10'b1111111111, 10'b0000000001);
    run("run2", 0, 10, 10'h3FF, 3, 4'd0, 1'b0,
        10'b0000000011, 10'b0000000100, 10'b0000000001, 10'b1111111111, 10'b0000000111);
    // duty=0: never high, never matches.
    run("run0", 0, 10, 10'h3FF, 3, 4'd15, 1'b0,
        10'b0000000000, 10'b0000000000, 10'b0000000001, 10'b1111111111, 10'b0000000111);
    // duty=15 > max count: always high; en dropped at cnt 6 forces low.
    run("run15", 0, 10, 10'b0000111111, -1, 4'd0, 1'b0,
        10'b0000111111, 10'b0000000000, 10'b0000000001, 10'b0000111111, 10'b1111111111);
    // One-shot duty=3 loaded while disabled.
    run("os_load", 0, 10, 10'h000, 0, 4'd3, 1'b1,
        10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000);
    run("os_run", 0, 10, 10'h3FF, -1, 4'd0, 1'b0,
        10'b0000000111, 10'b0000001000, 10'b0000000000, 10'b1111111111, 10'b1111111111);
    run("os_done", 0, 10, 10'h3FF, -1, 4'd0, 1'b0,
        10'b0000000000, 10'b0000000000, 10'b0000000001, 10'b0000000000, 10'b1111111111);
    // DONE ignores the wrap; en low at cnt 5 returns to IDLE.
    run("os_exit", 0, 10, 10'b0000011111, -1, 4'd0, 1'b0,
        10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b1111111111);
    run("os_rerun", 0, 2, 10'h3FF, -1, 4'd0, 1'b0,
        10'b0000000011, 10'b0000000000, 10'b0000000000, 10'b1111111111, 10'b1111111111);

    // Asynchronous reset during the high phase.
    rst_ = 1'b0;
    #1;
    chk("arst.pwm", pwm_out, 1'b0);
    chk("arst.match", match_pulse, 1'b0);
    chk("arst.period", period_pulse, 1'b0);
    chk("arst.busy", busy, 1'b0);
    chk("arst.ready", cfg_ready, 1'b1);
    tick();
    rst_ = 1'b1;

    // After reset nothing runs until a new config meets a wrap.
    run("post_rst", 2, 8, 10'h3FF, -1, 4'd0, 1'b0,
        10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b1111111111);
    run("post_load", 0, 10, 10'h3FF, 4, 4'd5, 1'b0,
        10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000000000, 10'b0000001111);
    run("post_run5", 0, 10, 10'h3FF, -1, 4'd0, 1'b0,
        10'b0000011111, 10'b0000100000, 10'b0000000000, 10'b1111111111, 10'b1111111111);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
